// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N-input valid/ready stream selector.
// Both the top level and the round-robin arbiter import this package.
package stream_mux_pkg;

    typedef enum logic {MODE_FIXED, MODE_RR} mux_mode_t;
    typedef enum logic {IDLE, LOCKED} mux_state_t;

    // Channel index following idx, wrapping at n back to zero.
    function automatic int next_index(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Purely combinational round-robin picker: the first requester at or after ptr_i wins.
// Produces a one-hot grant plus the index of the winner.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    logic          found_s;
    logic [IW-1:0] cand_s;

    // Rotating priority search starting at the pointer, wrapping modulo N.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = IW'((int'(ptr_i) + k) % N);
            if (!found_s && req_i[cand_s]) begin
                grant_o[cand_s] = 1'b1;
                idx_o           = cand_s;
                found_s         = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-input valid/ready selector with a registered output stage, fixed or round-robin
// source selection, and burst lock from first beat until last.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 3,
    localparam int SEL_WIDTH = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mode,
    input  logic [SEL_WIDTH-1:0]             select,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    input  logic [NUM_INPUTS-1:0]            in_last,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SEL_WIDTH-1:0]             out_chan,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready
);

    mux_state_t             state_q;
    logic [SEL_WIDTH-1:0]   lock_chan_q;
    logic [SEL_WIDTH-1:0]   rr_ptr_q;
    logic [SEL_WIDTH-1:0]   rr_ptr_d;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic [DATA_WIDTH-1:0]  out_data_d;
    logic [SEL_WIDTH-1:0]   out_chan_q;
    logic [SEL_WIDTH-1:0]   out_chan_d;
    logic                   out_last_q;
    logic                   out_last_d;
    logic                   out_valid_q;
    logic                   out_valid_d;

    mux_mode_t              mode_s;
    logic                   sel_ok_s;
    logic                   load_s;
    logic                   take_s;
    logic                   last_s;
    logic [NUM_INPUTS-1:0]  grant_s;
    logic [SEL_WIDTH-1:0]   gidx_s;
    logic [NUM_INPUTS-1:0]  arb_grant_s;
    logic [SEL_WIDTH-1:0]   arb_idx_s;

    assign mode_s   = mux_mode_t'(mode);
    assign sel_ok_s = (int'(select) < NUM_INPUTS);
    assign load_s   = !out_valid_q || out_ready;
    assign take_s   = load_s && (grant_s != '0);
    assign last_s   = in_last[gidx_s];
    assign in_ready = load_s ? grant_s : '0;

    rr_arbiter #(
        .N (NUM_INPUTS)
    ) u_arb (
        .req_i   (in_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant_s),
        .idx_o   (arb_idx_s)
    );

    // Grant source: the locked channel wins outright; otherwise fixed select or round-robin.
    always_comb begin
        grant_s = '0;
        gidx_s  = '0;
        case (state_q)
            LOCKED: begin
                if (in_valid[lock_chan_q]) begin
                    grant_s[lock_chan_q] = 1'b1;
                    gidx_s               = lock_chan_q;
                end else begin
                    grant_s = '0;
                end
            end
            IDLE: begin
                if (mode_s == MODE_RR) begin
                    grant_s = arb_grant_s;
                    gidx_s  = arb_idx_s;
                end else if (sel_ok_s && in_valid[select]) begin
                    grant_s[select] = 1'b1;
                    gidx_s          = select;
                end else begin
                    grant_s = '0;
                end
            end
            default: begin
                grant_s = '0;
            end
        endcase
    end

    // Output-stage and pointer next-state; a stall or an empty load keeps the held beat intact.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (take_s) begin
            out_data_d  = in_data[int'(gidx_s)*DATA_WIDTH +: DATA_WIDTH];
            out_chan_d  = gidx_s;
            out_last_d  = last_s;
            out_valid_d = 1'b1;
        end else if (load_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (take_s && last_s && (mode_s == MODE_RR)) begin
            rr_ptr_d = SEL_WIDTH'(next_index(int'(gidx_s), NUM_INPUTS));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Burst-lock FSM, arbitration pointer and registered output beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_chan_q <= '0;
            rr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            case (state_q)
                IDLE: begin
                    if (take_s && !last_s) begin
                        state_q     <= LOCKED;
                        lock_chan_q <= gidx_s;
                    end
                end
                LOCKED: begin
                    if (take_s && last_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a transaction-level model is compared every cycle,
// and hand-computed literals pin the model on each scenario.
module tb_stream_mux_rr;

    localparam int DW = 32;
    localparam int N  = 3;
    localparam int SW = 2;

    logic            clk;
    logic            rst;
    logic            mode;
    logic [SW-1:0]   select;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_chan;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;

    int total = 0;
    int bad   = 0;

    // model state
    logic            m_valid;
    logic [DW-1:0]   m_data;
    int              m_chan;
    logic            m_last;
    logic            m_locked;
    int              m_lock;
    int              m_ptr;

    stream_mux_rr #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .select    (select),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Channel that should be granted now, or -1 when none.
    function automatic int mdl_pick();
        int c;
        if (m_locked) begin
            return in_valid[m_lock] ? m_lock : -1;
        end
        if (mode == 1'b0) begin
            if (int'(select) < N && in_valid[select]) return int'(select);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_chan   <= 0;
            m_last   <= 1'b0;
            m_locked <= 1'b0;
            m_lock   <= 0;
            m_ptr    <= 0;
        end else if (!m_valid || out_ready) begin
            if (mdl_pick() >= 0) begin
                m_valid <= 1'b1;
                m_chan  <= mdl_pick();
                m_data  <= in_data[mdl_pick()*DW +: DW];
                m_last  <= in_last[mdl_pick()];
                if (!in_last[mdl_pick()]) begin
                    m_locked <= 1'b1;
                    m_lock   <= mdl_pick();
                end else begin
                    m_locked <= 1'b0;
                end
                if (in_last[mdl_pick()] && mode) m_ptr <= (mdl_pick() + 1) % N;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    initial begin
        int p;
        logic [N-1:0] exp_rdy;
        forever begin
            @(negedge clk);
            if (!rst) begin
                p = mdl_pick();
                exp_rdy = '0;
                if ((!m_valid || out_ready) && p >= 0) exp_rdy[p] = 1'b1;
                check("mdl_valid", 64'(out_valid), 64'(m_valid));
                check("mdl_data",  64'(out_data),  64'(m_data));
                check("mdl_chan",  64'(out_chan),  64'(m_chan));
                check("mdl_last",  64'(out_last),  64'(m_last));
                check("mdl_ready", 64'(in_ready),  64'(exp_rdy));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        select    = 2'd0;
        in_valid  = 3'b000;
        in_last   = 3'b000;
        out_ready = 1'b1;
        in_data   = '0;
        in_data[0*DW +: DW] = 32'hA;
        in_data[1*DW +: DW] = 32'hB;
        in_data[2*DW +: DW] = 32'hC;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid", 64'(out_valid), 64'(1'b0));
        check("reset_data",  64'(out_data),  64'(32'h0));
        check("reset_chan",  64'(out_chan),  64'(2'd0));

        // 1: fixed select=1
        @(posedge clk); #1;
        select = 2'd1; in_valid = 3'b111; in_last = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t1_data",  64'(out_data),  64'(32'hB));
        check("t1_chan",  64'(out_chan),  64'(2'd1));
        check("t1_valid", 64'(out_valid), 64'(1'b1));
        check("t1_ready", 64'(in_ready),  64'(3'b010));

        // 2: out-of-range select drains the output
        @(posedge clk); #1;
        select = 2'd3;
        @(negedge clk);
        check("t2_ready",      64'(in_ready),  64'(3'b000));
        check("t2_valid_held", 64'(out_valid), 64'(1'b1));
        @(negedge clk);
        check("t2_valid_drop", 64'(out_valid), 64'(1'b0));

        // 3: round-robin single beats
        @(posedge clk); #1;
        mode = 1'b1; select = 2'd0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("t3_chan",  64'(out_chan),  64'(i % N));
            check("t3_valid", 64'(out_valid), 64'(1'b1));
        end
        #1 in_valid = 3'b000;

        // 4: ch0 3-beat burst holds the lock
        @(posedge clk); #1;
        in_valid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            in_last = {2'b11, (i >= 2) ? 1'b1 : 1'b0};
            in_data[0*DW +: DW] = 32'h100 + 32'(i);
            @(negedge clk);
            check("t4_ready", 64'(in_ready), 64'((i < 3) ? 3'b001 : 3'b010));
            if (i > 0) check("t4_chan_burst", 64'(out_chan), 64'(2'd0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("t4_chan_after", 64'(out_chan), 64'(2'd1));
        #1;
        in_valid = 3'b000;
        in_last  = 3'b111;
        in_data[0*DW +: DW] = 32'hA;

        // 5: backpressure holds the beat, release loads in the same cycle
        @(posedge clk); #1;
        in_valid = 3'b111; out_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_hold_data",  64'(out_data),  64'(32'hC));
            check("t5_hold_chan",  64'(out_chan),  64'(2'd2));
            check("t5_hold_valid", 64'(out_valid), 64'(1'b1));
            check("t5_hold_ready", 64'(in_ready),  64'(3'b000));
        end
        #1 out_ready = 1'b1;
        #1 check("t5_release_ready", 64'(in_ready), 64'(3'b001));
        @(negedge clk);
        check("t5_next_data", 64'(out_data), 64'(32'hA));
        check("t5_next_chan", 64'(out_chan), 64'(2'd0));

        // 6: async reset mid-burst
        @(posedge clk); #1;
        in_valid = 3'b001; in_last = 3'b000;
        @(negedge clk);
        @(negedge clk);
        check("t6_burst_valid", 64'(out_valid), 64'(1'b1));
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'(1'b0));
        check("t6_rst_data",  64'(out_data),  64'(32'h0));
        in_valid = 3'b100; in_last = 3'b100;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check("t6_ready_ch2", 64'(in_ready), 64'(3'b100));
        @(posedge clk);
        @(negedge clk);
        check("t6_chan2", 64'(out_chan),  64'(2'd2));
        check("t6_valid", 64'(out_valid), 64'(1'b1));
        #1 in_valid = 3'b111; in_last = 3'b111;
        @(posedge clk);
        @(negedge clk);
        check("t6_ptr_wrap", 64'(out_chan), 64'(2'd0));

        @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
